// File: rtl/miner_pkg.sv
// miner_pkg: constants shared by the mining sequencer and its helpers.
//   K_TABLE      SHA-256 round constants K[0..63]
//   PAD_*        padding words injected into the message schedule
//   CNT_W        round counter width
//   CNT_LAST_DEF default final counter value of one pass
//   GNON_FIFO_DEPTH  golden nonce FIFO depth (used with GNON_FIFO_EN)
package miner_pkg;

    localparam int CNT_W           = 8;
    localparam int CNT_LAST_DEF    = 67;
    localparam int GNON_FIFO_DEPTH = 4;

    localparam logic [31:0] PAD_ONE  = 32'h8000_0000;
    localparam logic [31:0] PAD_LEN1 = 32'h0000_0280;  // 640-bit first-hash length
    localparam logic [31:0] PAD_LEN2 = 32'h0000_0100;  // 256-bit second-hash length

    localparam logic [31:0] K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/gnon_fifo.sv
// gnon_fifo: small show-ahead FIFO of 32-bit golden nonces.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_push       write i_data (caller guarantees !o_full or a same-cycle pop)
//   i_pop        drop the head entry (caller guarantees !o_empty)
//   o_full/o_empty  occupancy flags
//   o_head       oldest entry, valid while !o_empty
// DEPTH must be a power of two so the pointers wrap naturally.
module gnon_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  logic [31:0] i_data,
    input  logic        i_pop,
    output logic        o_full,
    output logic        o_empty,
    output logic [31:0] o_head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Push and pop together (even when full) leave occupancy unchanged.
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/microcore_seq.sv
// microcore_seq: round sequencer feeding NCORES SHA-256d hashing cores.
// Walks cnt 0..CNT_LAST twice per nonce batch (pass 0 = first hash,
// pass 1 = second hash), presents the round constant and message word for
// the current cnt, advances the nonce base by NCORES per pass pair and
// collects golden hits reported by the cores.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   work_valid/work_ready      work item handshake
//   work_midstate, work_data   work item (data word i = work_data[95-32*i -: 32])
//   midstate, m7               active midstate; m7 = midstate word 0 ([255:224])
//   cnt, pass, k_in, r1_in     per-round feed to the cores, all aligned to cnt
//   gnon                       per-core hit flags, sampled at cnt==1, pass==0
//   golden_valid/ack/nonce     golden nonce output, popped by golden_ack
//   busy                       work loaded and nonce space not exhausted
// Build option: GNON_FIFO_EN selects a 4-deep golden FIFO instead of a
// single holding register.
// NONCE_START is the base loaded on accept; 0 for normal mining, a nonzero
// value lets a short run reach the end of the nonce space.
module microcore_seq
    import miner_pkg::*;
#(
    parameter int          NCORES      = 8,
    parameter int          CNT_LAST    = CNT_LAST_DEF,
    parameter logic [31:0] NONCE_START = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              work_valid,
    output logic              work_ready,
    input  logic [255:0]      work_midstate,
    input  logic [95:0]       work_data,
    output logic [255:0]      midstate,
    output logic [31:0]       m7,
    output logic [CNT_W-1:0]  cnt,
    output logic              pass,
    output logic [31:0]       k_in,
    output logic [31:0]       r1_in,
    input  logic [NCORES-1:0] gnon,
    output logic              golden_valid,
    input  logic              golden_ack,
    output logic [31:0]       golden_nonce,
    output logic              busy
);
    seq_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_pass, w_pass_next;
    logic [31:0]      r_nonce_base, w_base_next, w_base_inc;
    logic [31:0]      r_prev_base, w_prev_next;
    logic [255:0]     r_mid;
    logic [95:0]      r_data, w_data_next;
    logic [31:0]      r_k_in, w_k_next;
    logic [31:0]      r_r1_in, w_r1_next;
    logic [31:0]      w_data_word [3];
    logic             w_wrap0, w_wrap1, w_accept, w_load;
    logic             w_hit;
    logic [31:0]      w_hit_idx, w_hit_nonce;

    assign w_wrap0    = (r_cnt == CNT_W'(CNT_LAST)) && !r_pass;
    assign w_wrap1    = (r_cnt == CNT_W'(CNT_LAST)) && r_pass;
    assign work_ready = (r_state == S_IDLE) || w_wrap1;
    assign w_accept   = work_valid && work_ready;
    assign w_base_inc = r_nonce_base + 32'(NCORES);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pass_next  = r_pass;
        w_base_next  = r_nonce_base;
        w_prev_next  = r_prev_base;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                    w_load       = 1'b1;
                    w_cnt_next   = '0;
                    w_pass_next  = 1'b0;
                    w_base_next  = NONCE_START;
                end
            end
            S_RUN: begin
                if (w_wrap1) begin
                    w_prev_next = r_nonce_base;
                    w_cnt_next  = '0;
                    w_pass_next = 1'b0;
                    if (w_accept) begin
                        w_load      = 1'b1;
                        w_base_next = NONCE_START;
                    end else begin
                        w_base_next = w_base_inc;
                        // Base wrapping to 0 means every nonce has been tried.
                        if (w_base_inc == '0) begin
                            w_state_next = S_IDLE;
                        end
                    end
                end else if (w_wrap0) begin
                    w_cnt_next  = '0;
                    w_pass_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_data_next = w_load ? work_data : r_data;

    for (genvar gi = 0; gi < 3; gi++) begin : g_data_word
        assign w_data_word[gi] = w_data_next[95-32*gi -: 32];
    end

    // k_in and r1_in are looked up from the next cnt/pass so the registered
    // values line up with cnt on the same cycle.
    always_comb begin
        w_k_next  = '0;
        w_r1_next = '0;
        if (w_state_next == S_RUN) begin
            if (w_cnt_next < CNT_W'(64)) begin
                w_k_next = K_TABLE[w_cnt_next[5:0]];
            end
            if (!w_pass_next) begin
                case (w_cnt_next)
                    CNT_W'(0):  w_r1_next = w_data_word[0];
                    CNT_W'(1):  w_r1_next = w_data_word[1];
                    CNT_W'(2):  w_r1_next = w_data_word[2];
                    CNT_W'(3):  w_r1_next = w_base_next;
                    CNT_W'(4):  w_r1_next = PAD_ONE;
                    CNT_W'(15): w_r1_next = PAD_LEN1;
                    default:    w_r1_next = '0;
                endcase
            end else begin
                case (w_cnt_next)
                    CNT_W'(8):  w_r1_next = PAD_ONE;
                    CNT_W'(15): w_r1_next = PAD_LEN2;
                    default:    w_r1_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pass       <= 1'b0;
            r_nonce_base <= '0;
            r_prev_base  <= '0;
            r_mid        <= '0;
            r_data       <= '0;
            r_k_in       <= '0;
            r_r1_in      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_pass       <= w_pass_next;
            r_nonce_base <= w_base_next;
            r_prev_base  <= w_prev_next;
            r_data       <= w_data_next;
            r_k_in       <= w_k_next;
            r_r1_in      <= w_r1_next;
            if (w_load) begin
                r_mid <= work_midstate;
            end
        end
    end

    // Hits are only meaningful at cnt==1 of pass 0; lowest core index wins.
    assign w_hit = (r_state == S_RUN) && (r_cnt == CNT_W'(1)) && !r_pass && (|gnon);

    always_comb begin
        w_hit_idx = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (gnon[i]) begin
                w_hit_idx = 32'(i);
            end
        end
    end

    assign w_hit_nonce = r_prev_base + w_hit_idx;

`ifdef GNON_FIFO_EN
    logic        w_fifo_full, w_fifo_empty, w_fifo_push, w_fifo_pop;
    logic [31:0] w_fifo_head;

    assign w_fifo_pop  = golden_ack && !w_fifo_empty;
    // A pop in the same cycle frees the slot, so a hit is never lost to an ack.
    assign w_fifo_push = w_hit && (!w_fifo_full || w_fifo_pop);

    gnon_fifo #(
        .DEPTH (GNON_FIFO_DEPTH)
    ) u_gnon_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_fifo_push),
        .i_data  (w_hit_nonce),
        .i_pop   (w_fifo_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    assign golden_valid = !w_fifo_empty;
    assign golden_nonce = w_fifo_empty ? 32'h0 : w_fifo_head;
`else
    logic        r_gold_valid;
    logic [31:0] r_gold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gold_valid <= 1'b0;
            r_gold       <= '0;
        end else if (w_hit && (!r_gold_valid || golden_ack)) begin
            r_gold_valid <= 1'b1;
            r_gold       <= w_hit_nonce;
        end else if (golden_ack) begin
            r_gold_valid <= 1'b0;
        end
    end

    assign golden_valid = r_gold_valid;
    assign golden_nonce = r_gold_valid ? r_gold : 32'h0;
`endif

    assign midstate = r_mid;
    assign m7       = r_mid[255:224];
    assign cnt      = r_cnt;
    assign pass     = r_pass;
    assign k_in     = r_k_in;
    assign r1_in    = r_r1_in;
    assign busy     = (r_state == S_RUN);

endmodule

// File: doc/microcore_seq.md
MICROCORE_SEQ -- requirements
Module: microcore_seq

Interface
REQ-001 Parameter NCORES, default 8: number of downstream hashing cores sharing this sequencer; power of two, 1..32.
REQ-002 Parameter CNT_LAST, default 67: final cnt value of one pass.
REQ-003 clk  input  1  the single clock; all logic is posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 work_valid  input  1  a new work item is offered.
REQ-006 work_ready  output  1  the work item is accepted on a cycle where work_valid && work_ready.
REQ-007 work_midstate  input  256  the midstate of the offered work item.
REQ-008 work_data  input  96  the three tail data words of the offered work item.
REQ-009 midstate  output  256  the active midstate, sent to the cores.
REQ-010 m7  output  32  the active m7 feed-forward word: midstate word 0.
REQ-011 cnt  output  8  the round counter.
REQ-012 pass  output  1  0 = first hash, 1 = second hash.
REQ-013 k_in  output  32  the round constant.
REQ-014 r1_in  output  32  the message word, or the base nonce when pass=0 and cnt=3.
REQ-015 gnon  input  NCORES  per-core golden hit flags.
REQ-016 golden_valid  output  1  a golden nonce is available.
REQ-017 golden_ack  input  1  pops the golden nonce.
REQ-018 golden_nonce  output  32  the full nonce of the hit: base + core index.
REQ-019 busy  output  1  work is loaded and the nonce space is not exhausted.

Function
REQ-020 cnt SHALL increment by one each cycle while busy.
REQ-021 At CNT_LAST, cnt SHALL wrap to 0 and pass SHALL toggle.
REQ-022 While idle, cnt and pass SHALL hold at 0.
REQ-023 k_in SHALL equal K[cnt] for cnt 0..63 and 0 otherwise, registered with one-cycle latency.
REQ-024 The k_in latency SHALL be absorbed so that k_in is aligned to the current cnt at the outputs.
REQ-025 r1_in, pass=0, by cnt: 0..2 = work_data words 0..2; 3 = nonce_base; 4 = 0x80000000; 5..14 = 0; 15 = 0x00000280; others = 0.
REQ-026 r1_in, pass=1, by cnt: 8 = 0x80000000; 9..14 = 0; 15 = 0x00000100; others = 0.
REQ-027 nonce_base SHALL advance by NCORES at each wrap from pass=1 to pass=0, with 32-bit arithmetic.
REQ-028 When the nonce_base increment wraps to 0, busy SHALL drop at that wrap, and the sequencer SHALL go idle awaiting new work.
REQ-029 work_ready SHALL be 1 when idle, or when cnt==CNT_LAST and pass==1.
REQ-030 On accept, midstate, m7 and data SHALL load, nonce_base SHALL clear to 0, and the next cycle SHALL be cnt=0, pass=0.
REQ-031 The hit nonce SHALL be prev_base, the base of the pass pair just completed, latched at each pass-1 wrap.
REQ-032 gnon SHALL be sampled only when cnt==1 and pass==0; any other hit SHALL be ignored.
REQ-033 If several gnon bits are set at once, the lowest index SHALL be recorded: golden_nonce = prev_base + index.
REQ-034 A hit arriving in the same cycle as a golden_ack pop SHALL be accepted, with no loss.
REQ-035 The sequencer states SHALL be: IDLE (no work) -> RUN on accept; RUN -> IDLE on exhaustion; RUN -> RUN on a wrap accept.

Reset
REQ-036 Reset SHALL clear cnt, pass, nonce_base, prev_base, golden storage, golden_valid, busy, midstate, m7, k_in and r1_in to 0, and SHALL set work_ready to 1.
REQ-037 Reset asserted mid-pass SHALL abandon the work; no stale golden nonce SHALL survive it.

Configuration
REQ-038 With GNON_FIFO_EN defined, golden nonces SHALL be held in a 4-deep FIFO.
REQ-039 With GNON_FIFO_EN defined, a hit arriving while the FIFO is full SHALL be dropped.
REQ-040 Without GNON_FIFO_EN, golden storage SHALL be a single register, and a new hit while golden_valid=1 SHALL be dropped.
REQ-041 A dropped hit SHALL never overwrite held data, in either configuration.

Structure
REQ-042 Shared package miner_pkg SHALL hold: the SHA-256 K[0..63] table, the padding constants 0x80000000, 0x280 and 0x100, CNT_W=8, and the default CNT_LAST.
REQ-043 There SHALL be one sub-module, gnon_fifo (depth parameter, 32-bit), instantiated only under GNON_FIFO_EN.

Verification
REQ-044 Load work with data {0x11111111,0x22222222,0x33333333} -> pass0 r1_in cnt0..3 = 0x11111111, 0x22222222, 0x33333333, 0x00000000; cnt4 = 0x80000000; cnt15 = 0x280.
REQ-045 Run two pass pairs with NCORES=8 -> nonce_base at cnt3 of the third pass0 = 0x00000010; k_in at cnt0 = 0x428a2f98; k_in at cnt63 = 0xc67178f2.
REQ-046 Assert gnon=8'b00100100 at cnt1/pass0 after the first pair -> golden_nonce = 0x00000002, golden_valid=1; gnon at cnt5 is ignored.
REQ-047 Preload nonce_base=0xFFFFFFF8 and NCORES=8; run to the pass1 wrap -> busy=0, cnt holds 0, work_ready=1.
REQ-048 With GNON_FIFO_EN, give 5 hits with no ack -> 4 stored in order, the 5th dropped; simultaneous ack and hit -> count unchanged.
REQ-049 Assert reset at cnt=40 with golden_valid=1 -> all outputs are 0 and work_ready=1 in the same cycle; normal sequencing resumes after reset and a new work load.
